// File: rtl/regfile_sb_pkg.sv
// regfile_sb_pkg: shared constants, scoreboard operation encoding and a
// popcount helper for the regfile_sb register file.
package regfile_sb_pkg;

   // Default geometry: the 8x8, two-read-port configuration.
   localparam int REGFILE_DATA_W   = 8;
   localparam int REGFILE_NUM_REGS = 8;
   localparam int REGFILE_NUM_RD   = 2;

   // Widest busy vector the popcount helper can count (NUM_REGS must not exceed it).
   localparam int REGFILE_POPCNT_W = 256;

   // Per-register scoreboard action for one clock edge.
   typedef enum logic [1:0] {
      SB_HOLD = 2'd0,
      SB_SET  = 2'd1,
      SB_CLR  = 2'd2
   } sb_op_e;

   // A new issue beats a completing write to the same register: the register
   // is now owed a result by the newer instruction.
   function automatic sb_op_e sb_op(input logic set, input logic clr);
      if (set) begin
         return SB_SET;
      end
      if (clr) begin
         return SB_CLR;
      end
      return SB_HOLD;
   endfunction

   // Number of set bits in a zero-extended vector.
   function automatic int unsigned popcount(input logic [REGFILE_POPCNT_W-1:0] v);
      int unsigned n;
      n = 0;
      for (int i = 0; i < REGFILE_POPCNT_W; i++) begin
         n += 32'(v[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// regfile_sb_if: decode/writeback-facing bus of the register file.
// master = pipeline control (decode + writeback), slave = regfile_sb.
// There is no handshake: every request is accepted on the clock edge where
// its enable is high, and read/busy results are combinational from state.
interface regfile_sb_if
   import regfile_sb_pkg::*;
#(
   parameter int DATA_W   = REGFILE_DATA_W,
   parameter int NUM_REGS = REGFILE_NUM_REGS,
   parameter int NUM_RD   = REGFILE_NUM_RD
);

   localparam int ADDR_W = $clog2(NUM_REGS);

   // Writeback port
   logic                     write_enable;
   logic [ADDR_W-1:0]        write_select;
   logic [DATA_W-1:0]        data_in;

   // Decode read ports (packed, port k in slice k)
   logic [NUM_RD*ADDR_W-1:0] read_select;
   logic [NUM_RD*DATA_W-1:0] data_out;
   logic [NUM_RD-1:0]        read_busy;

   // Issue (scoreboard set) port
   logic                     issue_enable;
   logic [ADDR_W-1:0]        issue_select;

   // Scoreboard status
   logic [ADDR_W:0]          busy_count;
   logic [NUM_REGS-1:0]      busy_vec;

   modport master (
      output write_enable, write_select, data_in,
      output read_select,
      output issue_enable, issue_select,
      input  data_out, read_busy, busy_count, busy_vec
   );

   modport slave (
      input  write_enable, write_select, data_in,
      input  read_select,
      input  issue_enable, issue_select,
      output data_out, read_busy, busy_count, busy_vec
   );

endinterface

// File: rtl/regfile_sb_scoreboard.sv
// regfile_sb_scoreboard: one pending-write bit per register plus a
// registered count of pending registers. Issues set a bit, writebacks clear
// it, and an issue on the same edge as a writeback to the same register wins.
module regfile_sb_scoreboard
   import regfile_sb_pkg::*;
#(
   parameter  int NUM_REGS = REGFILE_NUM_REGS,
   parameter  int ZERO_REG = 0,
   localparam int ADDR_W   = $clog2(NUM_REGS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                set_en_i,
   input  logic [ADDR_W-1:0]   set_sel_i,
   input  logic                clr_en_i,
   input  logic [ADDR_W-1:0]   clr_sel_i,
   output logic [NUM_REGS-1:0] busy_vec_o,
   output logic [ADDR_W:0]     busy_count_o
);

   logic [NUM_REGS-1:0]         busy_q;
   logic [NUM_REGS-1:0]         busy_d;
   logic [ADDR_W:0]             count_q;
   logic [ADDR_W:0]             count_d;
   logic [REGFILE_POPCNT_W-1:0] busy_ext;

   // Next busy vector: apply set/clear per register, register 0 pinned low when hardwired.
   always_comb begin
      busy_d = busy_q;
      for (int r = 0; r < NUM_REGS; r++) begin
         case (sb_op(set_en_i && (set_sel_i == ADDR_W'(r)),
                     clr_en_i && (clr_sel_i == ADDR_W'(r))))
            SB_SET:  busy_d[r] = 1'b1;
            SB_CLR:  busy_d[r] = 1'b0;
            default: busy_d[r] = busy_q[r];
         endcase
      end
      if (ZERO_REG != 0) begin
         busy_d[0] = 1'b0;
      end
   end

   // Count is taken from the next vector so the registered count always
   // matches the registered vector in the same cycle.
   always_comb begin
      busy_ext                 = '0;
      busy_ext[NUM_REGS-1:0]   = busy_d;
      count_d                  = (ADDR_W+1)'(popcount(busy_ext));
   end

   // Scoreboard state, cleared asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q  <= '0;
         count_q <= '0;
      end else begin
         busy_q  <= busy_d;
         count_q <= count_d;
      end
   end

   assign busy_vec_o   = busy_q;
   assign busy_count_o = count_q;

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: parametrised multi-read-port register file with a per-register
// pending-write scoreboard for RAW hazard detection.
// Optional build macro REGFILE_SB_BYPASS_EN: when defined, a read of the
// register being written this cycle returns the incoming data and its busy
// flag reads clear (unless that register is re-issued the same cycle).
module regfile_sb
   import regfile_sb_pkg::*;
#(
   parameter int DATA_W   = REGFILE_DATA_W,
   parameter int NUM_REGS = REGFILE_NUM_REGS,
   parameter int NUM_RD   = REGFILE_NUM_RD,
   parameter int ZERO_REG = 0
) (
   input  logic          clk,
   input  logic          rst,
   regfile_sb_if.slave   bus
);

   localparam int ADDR_W = $clog2(NUM_REGS);

   logic [DATA_W-1:0]   mem_q [NUM_REGS];
   logic                wr_commit;
   logic                iss_commit;
   logic [NUM_REGS-1:0] busy_vec_w;
   logic [DATA_W-1:0]   rd_data_w [NUM_RD];
   logic                rd_busy_w [NUM_RD];

   // Writes and issues aimed at a hardwired zero register are discarded.
   always_comb begin
      wr_commit  = bus.write_enable;
      iss_commit = bus.issue_enable;
      if ((ZERO_REG != 0) && (bus.write_select == '0)) begin
         wr_commit = 1'b0;
      end
      if ((ZERO_REG != 0) && (bus.issue_select == '0)) begin
         iss_commit = 1'b0;
      end
   end

   // Data array: single writeback port, cleared asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            mem_q[r] <= '0;
         end
      end else if (wr_commit) begin
         mem_q[bus.write_select] <= bus.data_in;
      end
   end

   regfile_sb_scoreboard #(
      .NUM_REGS (NUM_REGS),
      .ZERO_REG (ZERO_REG)
   ) u_scoreboard (
      .clk          (clk),
      .rst          (rst),
      .set_en_i     (iss_commit),
      .set_sel_i    (bus.issue_select),
      .clr_en_i     (bus.write_enable),
      .clr_sel_i    (bus.write_select),
      .busy_vec_o   (busy_vec_w),
      .busy_count_o (bus.busy_count)
   );

   assign bus.busy_vec = busy_vec_w;

   // Independent read ports; any number may address the same register.
   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_W-1:0] rsel;
      assign rsel = bus.read_select[k*ADDR_W +: ADDR_W];

      // Read data for port k: array value, optional same-cycle bypass, zero register last.
      always_comb begin
         rd_data_w[k] = mem_q[rsel];
`ifdef REGFILE_SB_BYPASS_EN
         if (bus.write_enable && (bus.write_select == rsel)) begin
            rd_data_w[k] = bus.data_in;
         end
`endif
         if ((ZERO_REG != 0) && (rsel == '0)) begin
            rd_data_w[k] = '0;
         end
      end

      // Busy flag for port k: registered bit, hidden by a bypassing write
      // unless the same register is being re-issued this cycle.
      always_comb begin
         rd_busy_w[k] = busy_vec_w[rsel];
`ifdef REGFILE_SB_BYPASS_EN
         if (bus.write_enable && (bus.write_select == rsel) &&
             !(bus.issue_enable && (bus.issue_select == rsel))) begin
            rd_busy_w[k] = 1'b0;
         end
`endif
      end
   end

   // Pack per-port results onto the bus.
   always_comb begin
      bus.data_out  = '0;
      bus.read_busy = '0;
      for (int k = 0; k < NUM_RD; k++) begin
         bus.data_out[k*DATA_W +: DATA_W] = rd_data_w[k];
         bus.read_busy[k]                 = rd_busy_w[k];
      end
   end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised multi-port register file. It is the next generation of the 8x8, two-read-port register file used by the 8-bit core.
- Adds configurable width, depth and read-port count.
- Adds an optional hardwired zero register.
- Adds a per-register scoreboard (pending-write tracking) so the control unit can detect RAW hazards and stall.
- Sits between the decode stage (read selects, busy queries) and the writeback stage (write port).

Parameters:
DATA_W, 8, register width in bits
NUM_REGS, 8, number of registers; power of two, >= 2
NUM_RD, 2, number of independent read ports, >= 1
ZERO_REG, 0, 1 = register 0 always reads 0, ignores writes, never busy
ADDR_W, $clog2(NUM_REGS), derived localparam, not overridable

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset; clears all registers and the scoreboard
write_enable  in  1  commit data_in to register write_select this cycle
write_select  in  ADDR_W  writeback destination
data_in  in  DATA_W  writeback data
read_select  in  NUM_RD*ADDR_W  packed read addresses; port k = bits [k*ADDR_W +: ADDR_W]
data_out  out  NUM_RD*DATA_W  packed read data, port k = [k*DATA_W +: DATA_W]
read_busy  out  NUM_RD  1 = register addressed by port k has a pending write
issue_enable  in  1  mark register issue_select as pending
issue_select  in  ADDR_W  destination of newly issued instruction
busy_count  out  ADDR_W+1  number of registers currently pending
busy_vec  out  NUM_REGS  raw scoreboard bits

Behaviour:
- Reset (async, active-high): all registers = 0, busy_vec = 0, busy_count = 0. While rst is high, writes and issues are ignored. Release is synchronous to clk.
- Write: on a rising edge with write_enable=1, reg[write_select] <= data_in. write_enable=0 means no register changes. There is no decode-to-register-0 side effect: the old register 0 aliasing on a disabled write is removed.
- Read: combinational from current state. data_out[k] = reg[read_select[k]]. Any number of ports may address the same register.
- Scoreboard, per register r, on a rising edge:
  - set = issue_enable && issue_select==r
  - clr = write_enable && write_select==r
  - set only -> busy 1; clr only -> busy 0; neither -> hold.
  - set && clr -> busy 1 (the new issue wins; the write still commits data).
- read_busy[k] = busy_vec[read_select[k]] (current state, combinational).
- busy_count = popcount(busy_vec), registered, so it is consistent with busy_vec in the same cycle. Range 0..NUM_REGS.
- Write to a non-busy register: allowed; data commits and busy stays 0.
- ZERO_REG=1:
  - Writes to r0 are dropped.
  - Issues to r0 are dropped.
  - busy_vec[0] is tied to 0.
  - data_out for r0 = 0, regardless of bypass.
- Latency: write visible on reads the cycle after commit, or the same cycle with bypass. Scoreboard update visible the cycle after set/clr.

Optional Feature:
Macro REGFILE_SB_BYPASS_EN.
- Defined: a read of write_select while write_enable=1 returns data_in in the same cycle. The matching read_busy[k] is also forced to 0 that cycle unless the same register is re-issued that cycle.
- Undefined: reads return the pre-write value. read_busy reflects registered state only.

Decomposition:
- Package regfile_sb_pkg holds:
  - default constants REGFILE_DATA_W=8, REGFILE_NUM_REGS=8, REGFILE_NUM_RD=2
  - a popcount function
- Sub-module regfile_sb_scoreboard holds the busy bit vector, set/clr priority and busy_count. It takes NUM_REGS and ZERO_REG as parameters.
- The data array and read muxing stay in the top module, built in generate loops over NUM_RD.

Test Plan:
- Reset: write 0xA5 to r3, assert rst mid-cycle (async) -> data_out reads 0 immediately, busy_vec=0, busy_count=0.
- Write/read: write r1=0x3C, r7=0xFF; next cycle read_select={7,1} -> data_out={0xFF,0x3C}; write_enable=0 with write_select=2, data_in=0x11 -> r2 unchanged, r0 unchanged.
- Scoreboard: issue r4 -> next cycle busy_vec[4]=1, busy_count=1, read_busy for port reading r4 =1; write r4=0x55 -> busy clears, busy_count=0.
- Simultaneous set/clr: r5 busy; same edge write r5=0x22 and issue r5 -> r5=0x22, busy_vec[5]=1, busy_count unchanged at 1.
- ZERO_REG=1: write r0=0x99, issue r0 -> data_out for r0 = 0, busy_vec[0]=0, busy_count=0.
- Bypass: write r6=0x77 and read r6 in the same cycle -> data_out=0x77 with REGFILE_SB_BYPASS_EN defined, old value 0x00 when undefined. Repeat with NUM_RD=4, DATA_W=16.
